// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter/sequencer in front of the cache_ctrl user port.
// Grants one requester, issues a single rd/wr strobe, waits for hit or busy completion, returns done/err/rdata.
module sdram_port_arbiter #(
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [W_ADDR-1:0] m0_addr,
  input  logic [W_DATA-1:0] m0_wdata,
  input  logic [3:0]        m0_mask,
  output logic              m0_done,
  output logic              m0_err,
  output logic [W_DATA-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [W_ADDR-1:0] m1_addr,
  input  logic [W_DATA-1:0] m1_wdata,
  input  logic [3:0]        m1_mask,
  output logic              m1_done,
  output logic              m1_err,
  output logic [W_DATA-1:0] m1_rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [W_ADDR-1:0] mem_addr,
  output logic [W_DATA-1:0] mem_wdata,
  output logic [3:0]        mem_mask,
  input  logic              mem_busy,
  input  logic              mem_hit,
  input  logic [W_DATA-1:0] mem_rdata,
  output logic              owner
);

  localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

  typedef struct packed {
    logic              we;
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] wdata;
    logic [3:0]        mask;
  } req_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE} state_t;

  state_t state, state_d;
  req_t   req_q, req_gnt;
  logic   owner_q, rr_last, err_q;
  logic   gnt_valid, gnt_sel;
  logic   fin, fin_err;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0][W_DATA-1:0] rdata_q;

  // rr_last holds the last granted port; ties go to the other one
  always_comb begin
    gnt_valid = m0_req | m1_req;
    if (m0_req && m1_req) gnt_sel = (FIXED_PRIO != 0) ? 1'b0 : !rr_last;
    else                  gnt_sel = !m0_req;
    req_gnt = gnt_sel ? req_t'{m1_we, m1_addr, m1_wdata, m1_mask}
                      : req_t'{m0_we, m0_addr, m0_wdata, m0_mask};
    req_gnt.addr = req_gnt.addr & ~W_ADDR'(3);
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state)
      IDLE:  if (gnt_valid) state_d = ISSUE;
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START, WAIT_DONE: begin
        if (state == WAIT_START && mem_busy) begin
          state_d = WAIT_DONE;
        end else if ((state == WAIT_START && !req_q.we && mem_hit) ||
                     (state == WAIT_DONE && !mem_busy)) begin
          state_d = DONE;
          fin     = 1'b1;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          // this is the TIMEOUT-th counted wait cycle
          state_d = DONE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      owner_q <= 1'b0;
      rr_last <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && gnt_valid) begin
        owner_q <= gnt_sel;
        req_q   <= req_gnt;
      end
      if (fin) begin
        err_q <= fin_err;
        if (fin_err)        rdata_q[owner_q] <= '0;
        else if (!req_q.we) rdata_q[owner_q] <= mem_rdata;
      end
      if (state == DONE) rr_last <= owner_q;
    end
  end

  always_comb begin
    mem_rd_en = (state == ISSUE) && !req_q.we;
    mem_wr_en = (state == ISSUE) &&  req_q.we;
    mem_addr  = req_q.addr;
    mem_wdata = req_q.wdata;
    mem_mask  = req_q.mask;
    owner     = owner_q;
    m0_done   = (state == DONE) && !owner_q;
    m1_done   = (state == DONE) &&  owner_q;
    m0_err    = m0_done && err_q;
    m1_err    = m1_done && err_q;
    m0_rdata  = rdata_q[0];
    m1_rdata  = rdata_q[1];
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: dut a is round-robin, dut b fixed-priority; both share stimulus, TIMEOUT=16.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_mask = 0, m1_mask = 0;
  logic        mem_busy = 0, mem_hit = 0;
  logic [31:0] mem_rdata = 0;

  logic        a_m0_done, a_m0_err, a_m1_done, a_m1_err, a_rd_en, a_wr_en, a_owner;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata;
  logic [3:0]  a_mask;
  logic        b_m0_done, b_m0_err, b_m1_done, b_m1_err, b_rd_en, b_wr_en, b_owner;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata;
  logic [3:0]  b_mask;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.W_ADDR(32), .W_DATA(32), .FIXED_PRIO(0), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
    .m0_done(a_m0_done), .m0_err(a_m0_err), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
    .m1_done(a_m1_done), .m1_err(a_m1_err), .m1_rdata(a_m1_rdata),
    .mem_rd_en(a_rd_en), .mem_wr_en(a_wr_en), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_mask(a_mask), .mem_busy(mem_busy), .mem_hit(mem_hit), .mem_rdata(mem_rdata),
    .owner(a_owner)
  );

  sdram_port_arbiter #(.W_ADDR(32), .W_DATA(32), .FIXED_PRIO(1), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
    .m0_done(b_m0_done), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
    .m1_done(b_m1_done), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
    .mem_rd_en(b_rd_en), .mem_wr_en(b_wr_en), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_mask(b_mask), .mem_busy(mem_busy), .mem_hit(mem_hit), .mem_rdata(mem_rdata),
    .owner(b_owner)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_m0_done", {31'd0, a_m0_done}, 0);
    chk("rst_rd_en",   {31'd0, a_rd_en}, 0);
    chk("rst_addr",    a_addr, 0);
    chk("rst_owner",   {31'd0, a_owner}, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // single read hit on m0
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_1006;
    mem_hit = 1; mem_rdata = 32'hDEAD_BEEF;
    tick;
    chk("hit_rd_en",   {31'd0, a_rd_en}, 1);
    chk("hit_wr_en",   {31'd0, a_wr_en}, 0);
    chk("hit_addr",    a_addr, 32'h0000_1004);
    chk("hit_done_e1", {31'd0, a_m0_done}, 0);
    tick;
    chk("hit_rd_en_e2", {31'd0, a_rd_en}, 0);
    chk("hit_done_e2",  {31'd0, a_m0_done}, 0);
    tick;
    m0_req = 0;
    chk("hit_done",   {31'd0, a_m0_done}, 1);
    chk("hit_err",    {31'd0, a_m0_err}, 0);
    chk("hit_rdata",  a_m0_rdata, 32'hDEAD_BEEF);
    chk("hit_m1_done", {31'd0, a_m1_done}, 0);
    tick;
    chk("hit_done_drop", {31'd0, a_m0_done}, 0);
    chk("hit_rdata_hold", a_m0_rdata, 32'hDEAD_BEEF);

    // write miss on m1, busy high for 10 cycles
    mem_hit = 0;
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h1234_5678; m1_mask = 4'b0011;
    tick;
    chk("wr_wr_en",  {31'd0, a_wr_en}, 1);
    chk("wr_rd_en",  {31'd0, a_rd_en}, 0);
    chk("wr_addr",   a_addr, 32'h200);
    chk("wr_wdata",  a_wdata, 32'h1234_5678);
    chk("wr_mask",   {28'd0, a_mask}, 32'h3);
    chk("wr_owner",  {31'd0, a_owner}, 1);
    mem_busy = 1;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("wr_wait_wr_en",   {31'd0, a_wr_en}, 0);
      chk("wr_wait_m1_done", {31'd0, a_m1_done}, 0);
    end
    mem_busy = 0;
    tick;
    m1_req = 0;
    chk("wr_m1_done", {31'd0, a_m1_done}, 1);
    chk("wr_m1_err",  {31'd0, a_m1_err}, 0);
    chk("wr_m0_done", {31'd0, a_m0_done}, 0);
    tick;
    chk("wr_m1_done_drop", {31'd0, a_m1_done}, 0);

    // contention: a alternates starting with m0 (m1 was last), b keeps m0
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    m1_req = 1; m1_we = 0; m1_addr = 32'h80;
    mem_hit = 1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("cont_a_owner", {31'd0, a_owner}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("cont_b_owner", {31'd0, b_owner}, 0);
      tick; tick;
      chk("cont_a_m0_done", {31'd0, a_m0_done}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_a_m1_done", {31'd0, a_m1_done}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("cont_b_m0_done", {31'd0, b_m0_done}, 1);
      chk("cont_b_m1_done", {31'd0, b_m1_done}, 0);
      tick;
    end
    m0_req = 0; m1_req = 0;
    tick;

    // timeout: busy stuck, 16 counted WAIT_DONE cycles
    mem_hit = 0; mem_busy = 1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    tick;
    chk("to_rd_en", {31'd0, a_rd_en}, 1);
    for (int k = 0; k < 17; k++) tick;
    chk("to_done_early", {31'd0, a_m0_done}, 0);
    tick;
    chk("to_done",  {31'd0, a_m0_done}, 1);
    chk("to_err",   {31'd0, a_m0_err}, 1);
    chk("to_rdata", a_m0_rdata, 0);
    m0_req = 0; mem_busy = 0;
    tick;
    chk("to_done_drop", {31'd0, a_m0_done}, 0);

    // normal read after timeout
    m0_req = 1; m0_addr = 32'h8; mem_hit = 1; mem_rdata = 32'hA5A5_0001;
    tick; tick; tick;
    m0_req = 0;
    chk("post_to_done",  {31'd0, a_m0_done}, 1);
    chk("post_to_err",   {31'd0, a_m0_err}, 0);
    chk("post_to_rdata", a_m0_rdata, 32'hA5A5_0001);
    tick;

    // reset during WAIT_DONE of an m1 write
    mem_hit = 0; mem_busy = 1;
    m1_req = 1; m1_we = 1; m1_addr = 32'h300; m1_wdata = 32'hCAFE_0000; m1_mask = 4'hF;
    tick; tick; tick;
    #2 rst_n = 0;
    #1;
    chk("rst_mid_addr",    a_addr, 0);
    chk("rst_mid_wdata",   a_wdata, 0);
    chk("rst_mid_mask",    {28'd0, a_mask}, 0);
    chk("rst_mid_owner",   {31'd0, a_owner}, 0);
    chk("rst_mid_m1_done", {31'd0, a_m1_done}, 0);
    chk("rst_mid_m0_rdata", a_m0_rdata, 0);
    tick;
    chk("rst_hold_m1_done", {31'd0, a_m1_done}, 0);
    rst_n = 1;
    mem_busy = 0; mem_hit = 1; mem_rdata = 32'h5555_AAAA;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_we = 0; m1_addr = 32'h20;
    tick;
    chk("rst_post_a_owner", {31'd0, a_owner}, 0);
    chk("rst_post_rd_en",   {31'd0, a_rd_en}, 1);
    chk("rst_post_addr",    a_addr, 32'h10);
    tick; tick;
    m0_req = 0; m1_req = 0;
    chk("rst_post_m0_done", {31'd0, a_m0_done}, 1);
    chk("rst_post_m1_done", {31'd0, a_m1_done}, 0);
    chk("rst_post_rdata",   a_m0_rdata, 32'h5555_AAAA);
    tick;

    // m1 withdraws req mid-transaction
    mem_hit = 0; mem_busy = 1;
    m1_req = 1; m1_we = 0; m1_addr = 32'h404;
    tick; tick; tick;
    m1_req = 0;
    tick; tick;
    chk("wd_done_early", {31'd0, a_m1_done}, 0);
    mem_rdata = 32'h0BAD_F00D; mem_busy = 0;
    tick;
    chk("wd_m1_done",  {31'd0, a_m1_done}, 1);
    chk("wd_m1_rdata", a_m1_rdata, 32'h0BAD_F00D);
    chk("wd_m0_rdata_hold", a_m0_rdata, 32'h5555_AAAA);
    tick;
    chk("wd_done_once_1", {31'd0, a_m1_done}, 0);
    tick;
    chk("wd_done_once_2", {31'd0, a_m1_done}, 0);
    chk("wd_idle_rd_en",  {31'd0, a_rd_en}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the SDRAM cache controller (`cache_ctrl`) on the Tang Nano 20K SoC.
- Lets the CPU data-side bus slave and a second master (DMA / video fetch) share the single `cache_ctrl` user port.
- Generates the one-cycle `rd_en`/`wr_en` pulses and tracks the fast-hit and busy completion paths.
- Returns data, a completion pulse and a timeout error to the granted requester.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width; fixed at 32 (`cache_ctrl` word).
- FIXED_PRIO, 0: 1 = m0 always wins ties; 0 = round-robin.
- TIMEOUT, 1024: max cycles waiting on the controller before an error completion; 0 disables. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock (same clock as `cache_ctrl` user side)
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  request; held with attributes stable until m0_done
- m0_we  in  1  1=write, 0=read
- m0_addr  in  W_ADDR  byte address; bits [1:0] ignored
- m0_wdata  in  W_DATA  write data
- m0_mask  in  4  byte enables
- m0_done  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_done; 1 = timeout
- m0_rdata  out  W_DATA  read data, valid with m0_done
- m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_done, m1_err, m1_rdata: same as m0
- mem_rd_en  out  1  read strobe to `cache_ctrl`
- mem_wr_en  out  1  write strobe to `cache_ctrl`
- mem_addr  out  W_ADDR  word-aligned address ({addr[W_ADDR-1:2],2'b00})
- mem_wdata  out  W_DATA  write data
- mem_mask  out  4  byte mask
- mem_busy  in  1  controller busy (`o_busy`)
- mem_hit  in  1  fast read hit (cache_state==0 && c_oe)
- mem_rdata  in  W_DATA  controller read data
- owner  out  1  current/last granted requester (debug)

Behaviour:
- Reset (asynchronous, any state): all outputs 0. State goes to IDLE, the round-robin pointer favours m0, and the timeout counter clears. An in-flight transaction is abandoned with no done pulse.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: m0 wins if FIXED_PRIO=1; otherwise the requester not granted last time wins.
  - On grant: latch owner, we, aligned addr, wdata, mask into registers driving mem_*, then go to ISSUE.
- ISSUE (exactly 1 cycle): mem_rd_en=!we, mem_wr_en=we. Clear the counter, then go to WAIT_START. Strobes are 0 in every other state.
- WAIT_START, checked in this order:
  - mem_busy=1 → WAIT_DONE.
  - Read with mem_hit=1 → capture mem_rdata, go to DONE.
  - Else increment the counter.
  - Writes ignore mem_hit.
- WAIT_DONE:
  - mem_busy=0 → capture mem_rdata (reads) and go to DONE.
  - Else increment the counter.
- Timeout: if TIMEOUT≠0 and the counter reaches TIMEOUT in WAIT_START/WAIT_DONE → go to DONE with err=1 and rdata=0.
- DONE (1 cycle):
  - Owner's mN_done=1, mN_err and mN_rdata driven from registers. The other port's done stays 0.
  - Update the round-robin pointer to the owner, then go to IDLE.
  - rdata holds its value until the next completion for that port.
- Latency: req seen in IDLE at cycle t → ISSUE at t+1 → WAIT_START at t+2.
  - Read hit: done at t+3.
  - Miss or write: done 1 cycle after the first cycle mem_busy is sampled 0 in WAIT_DONE.
- Requester rules:
  - req must drop the cycle after done unless a new request is intended. A registered master satisfies this; back-to-back requests from the same master are therefore legal.
  - Deasserting req mid-transaction has no effect: the transaction completes and done still pulses.
  - Request attributes change only after done; they are latched at grant, so later changes are ignored.
- Non-owner requests wait; there is no pre-emption.
- Round-robin fairness: with both masters continuously requesting, grants alternate m0, m1, m0, … starting with m0 after reset.

Test Plan:
- Single read hit: m0 read addr 0x0000_1006, mem_hit=1 at WAIT_START, mem_rdata=0xDEADBEEF → mem_rd_en pulse 1 cycle with mem_addr=0x0000_1004; m0_done 3 cycles after req, m0_rdata=0xDEADBEEF, m0_err=0.
- Write miss: m1 write 0x200, wdata 0x12345678, mask 4'b0011; mem_busy high for 10 cycles → mem_wr_en one pulse, m1_done 1 cycle after busy falls, m0_done stays 0.
- Contention: m0 and m1 request every cycle, FIXED_PRIO=0 → grant order m0,m1,m0,m1 over 4 transactions; with FIXED_PRIO=1 → m0 only while m0 keeps requesting.
- Timeout: TIMEOUT=16, read, mem_busy stuck 1 → m0_done with m0_err=1 and rdata=0 exactly 16 counted cycles after ISSUE; next request is served normally.
- Reset mid-operation: assert rst_n=0 during WAIT_DONE → all outputs 0 immediately with no done pulse; after release, m1+m0 simultaneous request → m0 granted first.
- Req withdrawn: m1 drops req during WAIT_DONE → transaction completes and m1_done still pulses once.
